guess_evaluator: RTL and testbench

GUESS_EVALUATOR -- requirements
Module: guess_evaluator

---
 rtl/guess_game_pkg.sv | 20 ++
 rtl/lfsr8.sv | 15 +
 rtl/guess_evaluator.sv | 99 +++++++++
 tb/tb_guess_evaluator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// Shared types and constants for the guessing game: FSM states, LFSR geometry and guess width.
package guess_game_pkg;
    localparam int LFSR_W = 8;
    // Feedback taps for x^8+x^6+x^5+x^4+1, as bit positions 7,5,4,3 of the shift register
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 8'hA5;
    localparam int GUESS_W = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_GUESS = 3'd1,
        SHOW       = 3'd2,
        WIN        = 3'd3,
        LOSE       = 3'd4
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR, free-running outside reset.
// Latency: q updates one cycle after each edge; no backpressure.
module lfsr8
    import guess_game_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n) q <= seed;
        else        q <= lfsr_next(q);
    end
endmodule

// File: rtl/guess_evaluator.sv
// Number-guessing game: compares guesses against an LFSR-drawn secret and reports low/high/correct.
// Result is registered (visible one cycle after the guess); SHOW holds it until the hold time has elapsed and the button is released.
module guess_evaluator
    import guess_game_pkg::*;
#(
    parameter int              MAX_TRIES   = 8,
    parameter int              HOLD_CYCLES = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [GUESS_W-1:0] player_guess,
    input  logic               guess_submitted,
    input  logic               new_game,
    output logic               ready,
    output logic               too_low,
    output logic               too_high,
    output logic               correct,
    output logic               game_over,
    output logic [3:0]         attempts,
    output logic [GUESS_W-1:0] secret_reveal
);
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    state_t             state, state_nxt;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [GUESS_W-1:0] secret;
    logic [HC_W-1:0]    hold_cnt;
    logic               eval;
    logic               is_eq;
    logic [3:0]         attempts_inc;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    assign eval         = (state == WAIT_GUESS) && guess_submitted && !new_game;
    assign is_eq        = (player_guess == secret);
    assign attempts_inc = attempts + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (new_game) begin
            state_nxt = WAIT_GUESS;
        end else begin
            case (state)
                WAIT_GUESS: if (guess_submitted) begin
                    if (is_eq)                             state_nxt = WIN;
                    else if (attempts_inc == 4'(MAX_TRIES)) state_nxt = LOSE;
                    else                                   state_nxt = SHOW;
                end
                // Requiring release here is what turns a held button into a single evaluation
                SHOW: if (hold_cnt == HOLD_LAST && !guess_submitted) state_nxt = WAIT_GUESS;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            secret   <= '0;
            attempts <= '0;
            hold_cnt <= '0;
            too_low  <= 1'b0;
            too_high <= 1'b0;
            correct  <= 1'b0;
        end else if (new_game) begin
            secret   <= lfsr_q[GUESS_W-1:0];
            attempts <= '0;
            hold_cnt <= '0;
            too_low  <= 1'b0;
            too_high <= 1'b0;
            correct  <= 1'b0;
        end else if (eval) begin
            attempts <= attempts_inc;
            hold_cnt <= '0;
            too_low  <= (player_guess < secret);
            too_high <= (player_guess > secret);
            correct  <= is_eq;
        end else if (state == SHOW && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_comb begin
        ready         = (state == WAIT_GUESS);
        game_over     = (state == WIN) || (state == LOSE);
        secret_reveal = game_over ? secret : '0;
    end
endmodule

// File: tb/tb_guess_evaluator.sv
module tb_guess_evaluator;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] player_guess = '0;
    logic       guess_submitted = 1'b0;
    logic       new_game = 1'b0;
    logic       ready, too_low, too_high, correct, game_over;
    logic [3:0] attempts, secret_reveal;
    logic [7:0] lfsr_chk_q;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lfsr;
    logic [3:0] m_secret;

    always #5 clk = ~clk;

    guess_evaluator #(.MAX_TRIES(3), .HOLD_CYCLES(16), .SEED(SEED)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .player_guess    (player_guess),
        .guess_submitted (guess_submitted),
        .new_game        (new_game),
        .ready           (ready),
        .too_low         (too_low),
        .too_high        (too_high),
        .correct         (correct),
        .game_over       (game_over),
        .attempts        (attempts),
        .secret_reveal   (secret_reveal)
    );

    lfsr8 u_lfsr_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .q     (lfsr_chk_q)
    );

    // Reference LFSR and secret, written out from the polynomial independently of the RTL
    always @(posedge clk) begin
        if (!rst_n) begin
            m_lfsr   <= SEED;
            m_secret <= 4'h0;
        end else begin
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            if (new_game) m_secret <= m_lfsr[3:0];
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        chk("wait_ready_timeout", 8'(ready), 8'd1);
    endtask

    task automatic restart_seeded();
        rst_n = 1'b0; new_game = 1'b0; guess_submitted = 1'b0;
        step(); step();
        rst_n = 1'b1; new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    task automatic guess(input logic [3:0] g);
        player_guess = g; guess_submitted = 1'b1;
        step();
        guess_submitted = 1'b0;
    endtask

    initial begin
        int n, ready_seen, distinct, zeros, seq_bad;
        logic [3:0] g;
        logic [7:0] first;
        bit seen [256];

        // Reset state
        step(); step(); step();
        chk("rst_ready", 8'(ready), 8'd0);
        chk("rst_flags", 8'({too_low, too_high, correct}), 8'd0);
        chk("rst_game_over", 8'(game_over), 8'd0);
        chk("rst_attempts", 8'(attempts), 8'd0);
        chk("rst_reveal", 8'(secret_reveal), 8'd0);

        // Secret is SEED[3:0]=5 when new_game comes on the first cycle; guess it
        rst_n = 1'b1; new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("ng_ready", 8'(ready), 8'd1);
        guess(4'h5);
        chk("win_correct", 8'(correct), 8'd1);
        chk("win_game_over", 8'(game_over), 8'd1);
        chk("win_attempts", 8'(attempts), 8'd1);
        chk("win_reveal", 8'(secret_reveal), 8'h5);
        chk("win_ready", 8'(ready), 8'd0);

        // Low then high feedback, SHOW lasts exactly 16 cycles when released early
        restart_seeded();
        guess(4'h2);
        chk("low_flags", 8'({too_low, too_high, correct}), 8'b100);
        chk("low_attempts", 8'(attempts), 8'd1);
        chk("low_show_ready", 8'(ready), 8'd0);
        chk("low_reveal", 8'(secret_reveal), 8'h0);
        wait_ready(n);
        chk("show_len", 8'(n), 8'd16);
        guess(4'hC);
        chk("high_flags", 8'({too_low, too_high, correct}), 8'b010);
        chk("high_attempts", 8'(attempts), 8'd2);
        chk("high_show_ready", 8'(ready), 8'd0);
        step();
        chk("high_flags_hold", 8'({too_low, too_high, correct}), 8'b010);

        // Held button for 40 cycles: single evaluation, ready only after release
        restart_seeded();
        player_guess = 4'h3; guess_submitted = 1'b1;
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready) ready_seen++;
        end
        chk("held_ready_count", 8'(ready_seen), 8'd0);
        chk("held_attempts", 8'(attempts), 8'd1);
        chk("held_flags", 8'({too_low, too_high, correct}), 8'b100);
        guess_submitted = 1'b0;
        step();
        chk("held_release_ready", 8'(ready), 8'd1);

        // Loss after three wrong guesses with a model-derived secret
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        g = m_secret ^ 4'h8;
        for (int i = 0; i < 3; i++) begin
            guess(g);
            if (i < 2) wait_ready(n);
        end
        chk("lose_game_over", 8'(game_over), 8'd1);
        chk("lose_flags", 8'({too_low, too_high, correct}), 8'({g < m_secret, g > m_secret, 1'b0}));
        chk("lose_attempts", 8'(attempts), 8'd3);
        chk("lose_reveal", 8'(secret_reveal), 8'(m_secret));
        guess(m_secret);
        step();
        chk("lose_sticky_correct", 8'(correct), 8'd0);
        chk("lose_sticky_attempts", 8'(attempts), 8'd3);
        chk("lose_sticky_over", 8'(game_over), 8'd1);

        // new_game beats a simultaneous guess
        new_game = 1'b1;
        step();
        player_guess = m_secret; guess_submitted = 1'b1;
        step();
        new_game = 1'b0; guess_submitted = 1'b0;
        chk("prio_attempts", 8'(attempts), 8'd0);
        chk("prio_flags", 8'({too_low, too_high, correct}), 8'd0);
        chk("prio_ready", 8'(ready), 8'd1);

        // Reset in SHOW abandons the game; IDLE ignores guesses
        guess(m_secret ^ 4'h1);
        step(); step();
        rst_n = 1'b0;
        step();
        chk("midrst_outputs", 8'({ready, too_low, too_high, correct, game_over}), 8'd0);
        chk("midrst_attempts", 8'(attempts), 8'd0);
        chk("midrst_reveal", 8'(secret_reveal), 8'd0);
        rst_n = 1'b1;
        guess(4'h0);
        step();
        chk("idle_ignore_attempts", 8'(attempts), 8'd0);
        chk("idle_ready", 8'(ready), 8'd0);

        // LFSR period: 255 distinct nonzero values, matching the reference sequence
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        distinct = 0; zeros = 0; seq_bad = 0;
        first = lfsr_chk_q;
        for (int i = 0; i < 255; i++) begin
            if (lfsr_chk_q == 8'h00) zeros++;
            if (!seen[lfsr_chk_q]) begin
                seen[lfsr_chk_q] = 1'b1;
                distinct++;
            end
            if (lfsr_chk_q !== m_lfsr) seq_bad++;
            step();
        end
        chk("lfsr_distinct", 8'(distinct), 8'd255);
        chk("lfsr_zeros", 8'(zeros), 8'd0);
        chk("lfsr_seq", 8'(seq_bad), 8'd0);
        chk("lfsr_period", lfsr_chk_q, first);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
